// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter: one access outstanding, registered strobes.
// Define ARBITER_ROUND_ROBIN_EN for round-robin; fixed priority to 0 otherwise.
module memory_arbiter #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0_read,
  input  logic                      req0_write,
  input  logic [DATA_WIDTH/8-1:0]   req0_byte_en,
  input  logic [ADDRESS_BITS-1:0]   req0_address,
  input  logic [DATA_WIDTH-1:0]     req0_data,
  output logic                      req0_ready,
  output logic                      req0_resp_valid,
  output logic [DATA_WIDTH-1:0]     req0_resp_data,
  input  logic                      req1_read,
  input  logic                      req1_write,
  input  logic [DATA_WIDTH/8-1:0]   req1_byte_en,
  input  logic [ADDRESS_BITS-1:0]   req1_address,
  input  logic [DATA_WIDTH-1:0]     req1_data,
  output logic                      req1_ready,
  output logic                      req1_resp_valid,
  output logic [DATA_WIDTH-1:0]     req1_resp_data,
  input  logic                      memory_ready,
  output logic                      memory_read,
  output logic                      memory_write,
  output logic [DATA_WIDTH/8-1:0]   memory_byte_en,
  output logic [ADDRESS_BITS-1:0]   memory_address,
  output logic [DATA_WIDTH-1:0]     memory_data,
  input  logic                      memory_resp_valid,
  input  logic [DATA_WIDTH-1:0]     memory_resp_data,
  input  logic                      scan
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        owner;
  logic [31:0] cycle;
  logic        pend0;
  logic        pend1;
  logic        win;
  logic        accept;
  logic        resp_hit;

  logic                    sel_read;
  logic                    sel_write;
  logic [DATA_WIDTH/8-1:0] sel_be;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign pend0 = req0_read | req0_write;
  assign pend1 = req1_read | req1_write;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant;

  // Contention goes to whoever did not win last time.
  always_comb begin
    win = ~pend0;
    if (pend0 && pend1) win = ~last_grant;
  end

  // Remember the most recent winner.
  always_ff @(posedge clock) begin
    if (reset) last_grant <= 1'b1;
    else if (accept) last_grant <= win;
  end
`else
  // Requester 0 always wins contention.
  always_comb begin
    win = ~pend0;
  end
`endif

  assign sel_read  = win ? req1_read    : req0_read;
  assign sel_write = win ? req1_write   : req0_write;
  assign sel_be    = win ? req1_byte_en : req0_byte_en;
  assign sel_addr  = win ? req1_address : req0_address;
  assign sel_data  = win ? req1_data    : req0_data;

  // Next-state decode plus accept / response qualifiers.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    resp_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (memory_ready && (pend0 || pend1)) begin
          accept     = ~reset;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = memory_read ? WAIT_RESP : IDLE;
      end
      WAIT_RESP: begin
        if (memory_resp_valid) begin
          resp_hit   = ~reset;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready      = accept & ~win;
  assign req1_ready      = accept & win;
  assign req0_resp_valid = resp_hit & ~owner;
  assign req1_resp_valid = resp_hit & owner;
  assign req0_resp_data  = req0_resp_valid ? memory_resp_data : '0;
  assign req1_resp_data  = req1_resp_valid ? memory_resp_data : '0;

  // State, capture registers and free-running cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      cycle          <= 32'd0;
      memory_read    <= 1'b0;
      memory_write   <= 1'b0;
      memory_byte_en <= '0;
      memory_address <= '0;
      memory_data    <= '0;
    end else begin
      state        <= state_next;
      cycle        <= cycle + 32'd1;
      memory_read  <= 1'b0;
      memory_write <= 1'b0;
      if (accept) begin
        owner          <= win;
        memory_read    <= sel_read;
        memory_write   <= sel_write & ~sel_read;
        memory_byte_en <= sel_be;
        memory_address <= sel_addr;
        memory_data    <= sel_data;
      end
    end
  end

`ifndef SYNTHESIS
  localparam logic signed [63:0] SMIN = 64'(SCAN_CYCLES_MIN);
  localparam logic signed [63:0] SMAX = 64'(SCAN_CYCLES_MAX);
  logic signed [63:0] cycle_s;
  assign cycle_s = {32'd0, cycle};

  // Debug trace inside the configured cycle window.
  always_ff @(posedge clock) begin
    if (scan && cycle_s >= SMIN && cycle_s <= SMAX)
      $display("[scan] core=%0d cycle=%0d state=%s owner=%0d rd=%b wr=%b be=%h addr=%h data=%h",
               CORE, cycle, state.name(), owner, memory_read, memory_write,
               memory_byte_en, memory_address, memory_data);
  end
`endif

endmodule
